// File: rtl/tcm_boot_pkg.sv
// Shared types and constants for the instruction-TCM boot controller.
package tcm_boot_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned WE_W           = 4;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned TCM_WORD_BYTES = 4;
    localparam logic [WE_W-1:0] TCM_WE_ALL = 4'hf;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CPURST = 2'd2,
        RUN    = 2'd3
    } boot_state_t;

    // Byte address of word `idx`, wrapping modulo 2^32.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(TCM_WORD_BYTES);
    endfunction

endpackage

// File: rtl/tcm_boot_arb.sv
// Combinational TCM port mux: fetch owns the port in RUN, the write register otherwise.
module tcm_boot_arb
    import tcm_boot_pkg::*;
(
    input  logic              run,
    input  logic [WE_W-1:0]   wr_we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic [WE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data
);

    always_comb begin
        fetch_gnt = 1'b0;
        mem_we    = wr_we;
        mem_addr  = wr_addr;
        mem_data  = wr_data;
        if (run) begin
            fetch_gnt = fetch_req;
            mem_we    = '0;
            mem_addr  = fetch_addr;
        end
    end

endmodule

// File: rtl/tcm_boot_ctrl.sv
// Boot sequencer: streams an image into the instruction TCM, holds the core in reset, then hands over the port.
// Optional checksum accumulation enabled by defining TCM_BOOT_CHECKSUM_EN.
module tcm_boot_ctrl
    import tcm_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [LEN_W-1:0]  load_len_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic [WE_W-1:0]   mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              rst_cpu_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [LEN_W-1:0]  words_o,
    output logic [DATA_W-1:0] csum_o
);

    boot_state_t       state_q, state_d;
    logic [LEN_W-1:0]  len_q, words_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WE_W-1:0]   we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ld_ready_q, rst_cpu_q, busy_q, err_q;
    logic              len_ok_c, start_ok_c, start_bad_c, xfer_c, last_c;

    // Next-state and per-edge event decode.
    always_comb begin
        state_d     = state_q;
        start_ok_c  = 1'b0;
        start_bad_c = 1'b0;
        xfer_c      = 1'b0;
        last_c      = 1'b0;
        len_ok_c    = (load_len_i != '0) && (32'(load_len_i) <= 32'(MAX_WORDS));
        case (state_q)
            IDLE, RUN: begin
                if (load_start_i) begin
                    if (len_ok_c) begin
                        start_ok_c = 1'b1;
                        state_d    = LOAD;
                    end else begin
                        start_bad_c = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (ld_valid_i && ld_ready_q) begin
                    xfer_c = 1'b1;
                    if (words_q == len_q - LEN_W'(1)) begin
                        last_c  = 1'b1;
                        state_d = CPURST;
                    end
                end
            end
            CPURST: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, counters and the TCM write register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_ready_q <= 1'b0;
            rst_cpu_q  <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            words_q    <= '0;
            cnt_q      <= '0;
            we_q       <= '0;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
        end else begin
            ld_ready_q <= (state_d == LOAD);
            rst_cpu_q  <= (state_d != RUN);
            busy_q     <= (state_d == LOAD) || (state_d == CPURST);
            we_q       <= '0;
            if (start_ok_c) begin
                err_q   <= 1'b0;
                words_q <= '0;
                len_q   <= load_len_i;
            end
            if (start_bad_c) begin
                err_q <= 1'b1;
            end
            if (xfer_c) begin
                we_q    <= TCM_WE_ALL;
                addr_q  <= word_addr(BASE_ADDR, words_q);
                data_q  <= ld_data_i;
                words_q <= words_q + LEN_W'(1);
            end
            if (last_c) begin
                cnt_q <= CNT_W'(RST_CYCLES);
            end else if (state_q == CPURST) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef TCM_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok_c) begin
            csum_q <= '0;
        end else if (xfer_c) begin
            csum_q <= csum_q + ld_data_i;
        end
    end

    assign csum_o = csum_q;
`else
    assign csum_o = '0;
`endif

    tcm_boot_arb u_arb (
        .run        (state_q == RUN),
        .wr_we      (we_q),
        .wr_addr    (addr_q),
        .wr_data    (data_q),
        .fetch_req  (fetch_req_i),
        .fetch_addr (fetch_addr_i),
        .fetch_gnt  (fetch_gnt_o),
        .mem_we     (mem_we_o),
        .mem_addr   (mem_addr_o),
        .mem_data   (mem_data_o)
    );

    assign ld_ready_o = ld_ready_q;
    assign rst_cpu_o  = rst_cpu_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign words_o    = words_q;

endmodule
